// File: rtl/rv32_bus_pkg.sv
// Shared types for the instruction/data bus arbiter.
package rv32_bus_pkg;

    // Arbiter FSM states: idle, or holding the bus for the fetch or mem-stage port.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    // One bus request as seen on the external bus.
    typedef struct packed {
        logic        read;
        logic        write;
        logic [3:0]  mask;
        logic [31:0] address;
        logic [31:0] wdata;
    } bus_req_t;

endpackage

// File: rtl/rv32_bus_timer.sv
// Bus watchdog: loaded when an access goes multi-cycle, counts down while busy,
// and flags expiry on the last allowed busy cycle. TIMEOUT_CYCLES = 0 disables it.
module rv32_bus_timer #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_load,
    input  logic i_en,
    output logic o_expired
);

    localparam int            TW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] LOAD_VAL = (TIMEOUT_CYCLES > 0) ? TW'(TIMEOUT_CYCLES - 1) : '0;

    logic [TW-1:0] r_count;

    // Countdown register: clear wins over load, load wins over decrement.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= LOAD_VAL;
        end else if (i_en && (r_count != '0)) begin
            r_count <= r_count - TW'(1);
        end
    end

    assign o_expired = (TIMEOUT_CYCLES != 0) && i_en && (r_count == '0);

endmodule

// File: rtl/rv32_bus_arbiter.sv
// Shares one memory bus between the fetch port and the mem-stage data port.
// Data normally wins; a starvation counter forces one instruction grant after
// STARVE_LIMIT data completions. A watchdog completes hung accesses with a fault.
module rv32_bus_arbiter
    import rv32_bus_pkg::*;
#(
    parameter int STARVE_LIMIT   = 4,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_read_in,
    input  logic [31:0] instr_address_in,
    output logic        instr_ready_out,
    output logic [31:0] instr_read_value_out,
    input  logic        data_read_in,
    input  logic        data_write_in,
    input  logic [3:0]  data_write_mask_in,
    input  logic [31:0] data_address_in,
    input  logic [31:0] data_write_value_in,
    output logic        data_ready_out,
    output logic [31:0] data_read_value_out,
    output logic        bus_read_out,
    output logic        bus_write_out,
    output logic [3:0]  bus_write_mask_out,
    output logic [31:0] bus_address_out,
    output logic [31:0] bus_write_value_out,
    input  logic [31:0] bus_read_value_in,
    input  logic        bus_ready_in,
    output logic        bus_fault_out
);

    localparam int            SW         = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    state_t        r_state;
    state_t        w_state_nxt;
    bus_req_t      r_req;
    bus_req_t      w_req_d;
    bus_req_t      w_req_i;
    bus_req_t      w_bus;
    logic [SW-1:0] r_starve;
    logic          w_idle;
    logic          w_busy;
    logic          w_starved;
    logic          w_grant_d;
    logic          w_grant_i;
    logic          w_expired;
    logic          w_fault;
    logic          w_done;
    logic          w_win_d;
    logic [31:0]   w_rdata;

    assign w_idle    = (r_state == IDLE);
    assign w_busy    = !w_idle;
    assign w_starved = (STARVE_LIMIT != 0) && instr_read_in && (r_starve == STARVE_MAX);
    assign w_grant_d = w_idle && (data_read_in || data_write_in) && !w_starved;
    assign w_grant_i = w_idle && !w_grant_d && instr_read_in;

    // Requests as they would appear on the bus; instr fetches keep the old write data to avoid toggling.
    always_comb begin
        w_req_d         = '0;
        w_req_d.read    = data_read_in;
        w_req_d.write   = data_write_in;
        w_req_d.mask    = data_write_in ? data_write_mask_in : 4'b0000;
        w_req_d.address = data_address_in;
        w_req_d.wdata   = data_write_value_in;
        w_req_i         = '0;
        w_req_i.read    = 1'b1;
        w_req_i.address = instr_address_in;
        w_req_i.wdata   = r_req.wdata;
    end

    // Bus source: live winner while idle, captured request while busy, quiet strobes otherwise.
    always_comb begin
        w_bus = r_req;
        if (w_idle) begin
            if (w_grant_d) begin
                w_bus = w_req_d;
            end else if (w_grant_i) begin
                w_bus = w_req_i;
            end else begin
                w_bus.read  = 1'b0;
                w_bus.write = 1'b0;
                w_bus.mask  = 4'b0000;
            end
        end
    end

    assign w_fault = w_busy && !bus_ready_in && w_expired;
    assign w_done  = (w_busy || w_grant_d || w_grant_i) && (bus_ready_in || w_fault);
    assign w_win_d = w_idle ? w_grant_d : (r_state == BUSY_D);
    assign w_rdata = w_fault ? 32'h0 : bus_read_value_in;

    // Next-state logic: a grant only goes busy when the bus did not answer in the same cycle.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (!bus_ready_in) begin
                    if (w_grant_d) begin
                        w_state_nxt = BUSY_D;
                    end else if (w_grant_i) begin
                        w_state_nxt = BUSY_I;
                    end
                end
            end
            BUSY_I, BUSY_D: begin
                if (w_done) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Capture the winning request so requester changes during the access are ignored.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_req <= '0;
        end else if (w_grant_d || w_grant_i) begin
            r_req <= w_bus;
        end
    end

    // Starvation counter: data completions while fetch waits; an instr completion resets it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_starve <= '0;
        end else if (w_done && !w_win_d) begin
            r_starve <= '0;
        end else if (w_done && instr_read_in && (r_starve != STARVE_MAX)) begin
            r_starve <= r_starve + SW'(1);
        end
    end

    rv32_bus_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .i_clk     (clk),
        .i_rst_n   (reset),
        .i_clear   (w_done),
        .i_load    ((w_grant_d || w_grant_i) && !bus_ready_in),
        .i_en      (w_busy),
        .o_expired (w_expired)
    );

    // Outputs are forced quiet while reset is held, even if requests are still asserted.
    assign instr_ready_out      = reset && w_done && !w_win_d;
    assign data_ready_out       = reset && w_done && w_win_d;
    assign instr_read_value_out = reset ? w_rdata : 32'h0;
    assign data_read_value_out  = reset ? w_rdata : 32'h0;
    assign bus_fault_out        = reset && w_fault;
    assign bus_read_out         = reset && w_bus.read;
    assign bus_write_out        = reset && w_bus.write;
    assign bus_write_mask_out   = reset ? w_bus.mask : 4'b0000;
    assign bus_address_out      = reset ? w_bus.address : 32'h0;
    assign bus_write_value_out  = reset ? w_bus.wdata : 32'h0;

endmodule

// File: tb/tb_rv32_bus_arbiter.sv
// Scoreboard bench for rv32_bus_arbiter: a small bus model answers after a
// programmable wait, expected completions are queued when requests are driven.
module tb_rv32_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        instr_read_in;
    logic [31:0] instr_address_in;
    logic        instr_ready_out;
    logic [31:0] instr_read_value_out;
    logic        data_read_in;
    logic        data_write_in;
    logic [3:0]  data_write_mask_in;
    logic [31:0] data_address_in;
    logic [31:0] data_write_value_in;
    logic        data_ready_out;
    logic [31:0] data_read_value_out;
    logic        bus_read_out;
    logic        bus_write_out;
    logic [3:0]  bus_write_mask_out;
    logic [31:0] bus_address_out;
    logic [31:0] bus_write_value_out;
    logic [31:0] bus_read_value_in;
    logic        bus_ready_in;
    logic        bus_fault_out;

    int n_tests = 0;
    int n_fail  = 0;
    int wait_n  = 0;
    logic hang  = 1'b0;
    int bus_cnt;

    typedef struct {
        logic        port_d;
        logic [31:0] val;
        logic        chk_val;
        logic        fault;
    } exp_t;
    exp_t exp_q[$];

    rv32_bus_arbiter #(
        .STARVE_LIMIT   (4),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .instr_read_in        (instr_read_in),
        .instr_address_in     (instr_address_in),
        .instr_ready_out      (instr_ready_out),
        .instr_read_value_out (instr_read_value_out),
        .data_read_in         (data_read_in),
        .data_write_in        (data_write_in),
        .data_write_mask_in   (data_write_mask_in),
        .data_address_in      (data_address_in),
        .data_write_value_in  (data_write_value_in),
        .data_ready_out       (data_ready_out),
        .data_read_value_out  (data_read_value_out),
        .bus_read_out         (bus_read_out),
        .bus_write_out        (bus_write_out),
        .bus_write_mask_out   (bus_write_mask_out),
        .bus_address_out      (bus_address_out),
        .bus_write_value_out  (bus_write_value_out),
        .bus_read_value_in    (bus_read_value_in),
        .bus_ready_in         (bus_ready_in),
        .bus_fault_out        (bus_fault_out)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        return (a == 32'h100) ? 32'hDEADBEEF : ((a ^ 32'h5A5A_0000) + 32'h0000_1357);
    endfunction

    // Bus model: answers once the strobe has been up for wait_n extra cycles, unless hung.
    assign bus_ready_in      = (bus_read_out || bus_write_out) && !hang && (bus_cnt == wait_n);
    assign bus_read_value_in = mem_val(bus_address_out);

    always @(posedge clk or negedge reset) begin
        if (!reset) bus_cnt <= 0;
        else if (instr_ready_out || data_ready_out || bus_ready_in) bus_cnt <= 0;
        else if (bus_read_out || bus_write_out) bus_cnt <= bus_cnt + 1;
        else bus_cnt <= 0;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic expect_rsp(input logic d, input logic [31:0] v, input logic cv, input logic f);
        exp_t e;
        e.port_d  = d;
        e.val     = v;
        e.chk_val = cv;
        e.fault   = f;
        exp_q.push_back(e);
    endtask

    // Scoreboard: every completion (or fault) must match the oldest expected entry.
    always @(negedge clk) begin
        exp_t e;
        if (reset && (instr_ready_out || data_ready_out || bus_fault_out)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_ready", 32'(instr_ready_out | data_ready_out), 0);
            end else begin
                e = exp_q.pop_front();
                check("ready_port", 32'(data_ready_out), 32'(e.port_d));
                check("ready_excl", 32'(instr_ready_out & data_ready_out), 0);
                if (e.chk_val)
                    check("read_value", e.port_d ? data_read_value_out : instr_read_value_out, e.val);
                check("fault", 32'(bus_fault_out), 32'(e.fault));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int budget);
        logic ri, rd;
        int   c;
        c = 0;
        while (exp_q.size() != 0 && c < budget) begin
            @(negedge clk);
            ri = instr_ready_out;
            rd = data_ready_out;
            cyc();
            if (ri) instr_read_in = 1'b0;
            if (rd) begin
                data_read_in  = 1'b0;
                data_write_in = 1'b0;
            end
            c++;
        end
        if (exp_q.size() != 0) begin
            check("wait_budget", 32'(exp_q.size()), 0);
            exp_q.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        instr_read_in = 1'b0; instr_address_in = '0;
        data_read_in = 1'b0; data_write_in = 1'b0; data_write_mask_in = '0;
        data_address_in = '0; data_write_value_in = '0;

        // Reset values
        #2;
        check("rst_bus_read", 32'(bus_read_out), 0);
        check("rst_bus_write", 32'(bus_write_out), 0);
        check("rst_mask", 32'(bus_write_mask_out), 0);
        check("rst_addr", bus_address_out, 0);
        check("rst_irdy", 32'(instr_ready_out), 0);
        check("rst_drdy", 32'(data_ready_out), 0);
        check("rst_fault", 32'(bus_fault_out), 0);
        @(posedge clk); cyc();
        reset = 1'b1;
        cyc();

        // A: zero-wait instr read
        wait_n = 0;
        instr_read_in = 1'b1; instr_address_in = 32'h100;
        expect_rsp(1'b0, 32'hDEADBEEF, 1'b1, 1'b0);
        @(negedge clk);
        check("A_bus_read", 32'(bus_read_out), 1);
        check("A_addr", bus_address_out, 32'h100);
        check("A_irdy", 32'(instr_ready_out), 1);
        cyc();
        instr_read_in = 1'b0;
        @(negedge clk);
        check("A_idle_strobe", 32'(bus_read_out), 0);
        check("A_idle_addr_hold", bus_address_out, 32'h100);
        check("A_idle_irdy", 32'(instr_ready_out), 0);
        cyc();

        // B: both request, data wins and holds the bus for 3 cycles, then instr
        wait_n = 2;
        data_write_in = 1'b1; data_address_in = 32'h200; data_write_mask_in = 4'b0011;
        data_write_value_in = 32'h1122_3344;
        instr_read_in = 1'b1; instr_address_in = 32'h104;
        expect_rsp(1'b1, 32'h0, 1'b0, 1'b0);
        expect_rsp(1'b0, mem_val(32'h104), 1'b1, 1'b0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("B_addr", bus_address_out, 32'h200);
            check("B_write", 32'(bus_write_out), 1);
            check("B_mask", 32'(bus_write_mask_out), 32'h3);
            check("B_wdata", bus_write_value_out, 32'h1122_3344);
            check("B_irdy", 32'(instr_ready_out), 0);
            check("B_drdy", 32'(data_ready_out), 32'(c == 2));
            cyc();
        end
        data_write_in = 1'b0; data_write_mask_in = 4'b0000;
        wait_done(20);

        // C: data read withdrawn during BUSY_D, bus keeps the captured request
        wait_n = 3;
        data_read_in = 1'b1; data_address_in = 32'h300;
        expect_rsp(1'b1, mem_val(32'h300), 1'b1, 1'b0);
        @(negedge clk);
        check("C_read0", 32'(bus_read_out), 1);
        cyc();
        data_read_in = 1'b0; data_address_in = 32'h999;
        for (int c = 1; c < 4; c++) begin
            @(negedge clk);
            check("C_read_hold", 32'(bus_read_out), 1);
            check("C_addr_hold", bus_address_out, 32'h300);
            check("C_mask_hold", 32'(bus_write_mask_out), 0);
            check("C_drdy", 32'(data_ready_out), 32'(c == 3));
            cyc();
        end
        wait_done(3);

        // D: continuous data traffic, instr forced through after every 4 data completions
        wait_n = 0;
        data_read_in = 1'b1; data_address_in = 32'h400;
        instr_read_in = 1'b1; instr_address_in = 32'h500;
        for (int k = 0; k < 4; k++) expect_rsp(1'b1, mem_val(32'h400), 1'b1, 1'b0);
        expect_rsp(1'b0, mem_val(32'h500), 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) expect_rsp(1'b1, mem_val(32'h400), 1'b1, 1'b0);
        expect_rsp(1'b0, mem_val(32'h504), 1'b1, 1'b0);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("D_irdy", 32'(instr_ready_out), 32'(c == 4 || c == 9));
            check("D_drdy", 32'(data_ready_out), 32'(c != 4 && c != 9));
            cyc();
            if (c == 4) instr_address_in = 32'h504;
        end
        data_read_in = 1'b0; instr_read_in = 1'b0;
        wait_done(3);
        cyc();

        // E: hung bus, timeout completes the fetch with a fault after 8 busy cycles
        hang = 1'b1;
        instr_read_in = 1'b1; instr_address_in = 32'h600;
        expect_rsp(1'b0, 32'h0, 1'b1, 1'b1);
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            check("E_irdy", 32'(instr_ready_out), 32'(c == 8));
            check("E_fault", 32'(bus_fault_out), 32'(c == 8));
            cyc();
        end
        instr_read_in = 1'b0;
        @(negedge clk);
        check("E_fault_clear", 32'(bus_fault_out), 0);
        cyc();
        hang = 1'b0;

        // E2: bus answers in the same cycle the timer expires -> normal completion
        wait_n = 8;
        data_read_in = 1'b1; data_address_in = 32'h700;
        expect_rsp(1'b1, mem_val(32'h700), 1'b1, 1'b0);
        wait_done(12);
        cyc();

        // F: reset during BUSY_I abandons the access; retried after release
        wait_n = 5;
        instr_read_in = 1'b1; instr_address_in = 32'h800;
        cyc();
        @(negedge clk);
        check("F_busy_read", 32'(bus_read_out), 1);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("F_rst_read", 32'(bus_read_out), 0);
        check("F_rst_addr", bus_address_out, 0);
        check("F_rst_irdy", 32'(instr_ready_out), 0);
        check("F_rst_fault", 32'(bus_fault_out), 0);
        @(posedge clk); cyc();
        reset = 1'b1;
        expect_rsp(1'b0, mem_val(32'h800), 1'b1, 1'b0);
        wait_done(20);
        cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
